// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: streams bias/input/weight BRAMs, accumulates one neuron at a time,
// requantises (round, optional ReLU, saturate) and writes the output BRAM. FC_ARGMAX_EN adds class argmax.
module fc_layer_engine #(
   parameter int DATA_W  = 8,
   parameter int ACC_W   = 24,
   parameter int N_IN    = 128,
   parameter int N_OUT   = 5,
   parameter int SHIFT_W = 5,
   localparam int IN_AW  = (N_IN > 1) ? $clog2(N_IN) : 1,
   localparam int W_AW   = ((N_IN * N_OUT) > 1) ? $clog2(N_IN * N_OUT) : 1,
   localparam int OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_start,
   input  logic                      i_relu_en,
   input  logic [SHIFT_W-1:0]        i_shift,
   output logic                      o_busy,
   output logic                      o_done,
   output logic [IN_AW-1:0]          o_in_addr,
   input  logic signed [DATA_W-1:0]  i_in_data,
   output logic [W_AW-1:0]           o_w_addr,
   input  logic signed [DATA_W-1:0]  i_w_data,
   output logic [OUT_AW-1:0]         o_b_addr,
   input  logic signed [ACC_W-1:0]   i_b_data,
   output logic                      o_out_we,
   output logic [OUT_AW-1:0]         o_out_addr,
   output logic signed [DATA_W-1:0]  o_out_data,
   output logic [OUT_AW-1:0]         o_class_idx,
   output logic                      o_class_valid
);

   // Wide enough that the rounding constant and any shift up to 2**SHIFT_W-1 stay exact.
   localparam int EXT_W = ACC_W + (2 ** SHIFT_W) + 1;
   localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic [IN_AW-1:0]  LAST_K = IN_AW'(N_IN - 1);
   localparam logic [OUT_AW-1:0] LAST_O = OUT_AW'(N_OUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_WRITE, S_DONE} state_t;

   state_t                     r_state;
   state_t                     w_next;
   logic [OUT_AW-1:0]          r_out_idx;
   logic [IN_AW-1:0]           r_k;
   logic signed [ACC_W-1:0]    r_acc;
   logic                       r_relu;
   logic [SHIFT_W-1:0]         r_shift;
   logic [IN_AW-1:0]           w_in_addr;
   logic signed [2*DATA_W-1:0] w_prod;
   logic signed [ACC_W-1:0]    w_prod_ext;
   logic signed [DATA_W-1:0]   w_q;

   function automatic logic signed [DATA_W-1:0] requant(
      input logic signed [ACC_W-1:0] acc,
      input logic [SHIFT_W-1:0]      sh,
      input logic                    relu
   );
      logic signed [EXT_W-1:0] x;
      logic signed [EXT_W-1:0] rnd;
      x   = EXT_W'(acc);
      rnd = '0;
      if (sh != '0) rnd = EXT_W'(1) << (sh - 1'b1);
      x = (x + rnd) >>> sh;
      if (relu && (x < 0)) x = '0;
      if (x > SAT_MAX)      x = SAT_MAX;
      else if (x < SAT_MIN) x = SAT_MIN;
      return x[DATA_W-1:0];
   endfunction

   assign w_prod     = i_in_data * i_w_data;
   assign w_prod_ext = ACC_W'(w_prod);
   assign w_q        = requant(r_acc, r_shift, r_relu);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      o_busy     = (r_state != S_IDLE);
      o_done     = 1'b0;
      o_out_we   = 1'b0;
      o_out_addr = '0;
      o_out_data = '0;
      o_b_addr   = '0;
      o_w_addr   = '0;
      w_in_addr  = '0;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_BIAS;
         S_BIAS: begin
            w_next   = S_MAC;
            o_b_addr = r_out_idx;
         end
         S_MAC: begin
            if (r_k == LAST_K) w_next = S_WRITE;
            o_b_addr  = r_out_idx;
            w_in_addr = (r_k == LAST_K) ? LAST_K : r_k + 1'b1;
         end
         S_WRITE: begin
            w_next     = (r_out_idx == LAST_O) ? S_DONE : S_BIAS;
            o_out_we   = 1'b1;
            o_out_addr = r_out_idx;
            o_out_data = w_q;
         end
         S_DONE: begin
            w_next = S_IDLE;
            o_done = 1'b1;
         end
         default: w_next = S_IDLE;
      endcase
      if ((r_state == S_BIAS) || (r_state == S_MAC))
         o_w_addr = W_AW'(r_out_idx) * W_AW'(N_IN) + W_AW'(w_in_addr);
      o_in_addr = w_in_addr;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_out_idx <= '0;
         r_k       <= '0;
         r_acc     <= '0;
         r_relu    <= 1'b0;
         r_shift   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_out_idx <= '0;
               r_k       <= '0;
               if (i_start) begin
                  r_relu  <= i_relu_en;
                  r_shift <= i_shift;
               end
            end
            S_BIAS: r_k <= '0;
            S_MAC: begin
               // First tap folds in the bias fetched during BIAS; the sum wraps at ACC_W.
               r_acc <= (r_k == '0) ? (i_b_data + w_prod_ext) : (r_acc + w_prod_ext);
               if (r_k != LAST_K) r_k <= r_k + 1'b1;
            end
            S_WRITE: if (r_out_idx != LAST_O) r_out_idx <= r_out_idx + 1'b1;
            default: ;
         endcase
      end
   end

`ifdef FC_ARGMAX_EN
   logic signed [DATA_W-1:0] r_max;
   logic [OUT_AW-1:0]        r_max_idx;
   logic [OUT_AW-1:0]        r_class_idx;
   logic                     r_class_valid;
   logic                     w_better;

   // Strictly greater replaces, so ties keep the lowest index.
   assign w_better = (r_out_idx == '0) || (w_q > r_max);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_max         <= '0;
         r_max_idx     <= '0;
         r_class_idx   <= '0;
         r_class_valid <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && i_start) r_class_valid <= 1'b0;
         if (r_state == S_WRITE) begin
            if (w_better) begin
               r_max     <= w_q;
               r_max_idx <= r_out_idx;
            end
            if (r_out_idx == LAST_O) begin
               r_class_idx   <= w_better ? r_out_idx : r_max_idx;
               r_class_valid <= 1'b1;
            end
         end
      end
   end

   assign o_class_idx   = r_class_idx;
   assign o_class_valid = r_class_valid;
`else
   assign o_class_idx   = '0;
   assign o_class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fc_layer_engine.sv
// Bench for fc_layer_engine: BRAM models, write monitor and an arithmetic reference model of each neuron.
module tb_fc_layer_engine;
   localparam int DATA_W = 8, ACC_W = 24, N_IN = 4, N_OUT = 5, SHIFT_W = 5;
   localparam int IN_AW = $clog2(N_IN), W_AW = $clog2(N_IN * N_OUT), OUT_AW = $clog2(N_OUT);
   localparam int RUN_CYC = N_OUT * (N_IN + 2) + 1;
`ifdef FC_ARGMAX_EN
   localparam bit ARGMAX = 1'b1;
`else
   localparam bit ARGMAX = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, relu_en = 1'b0;
   logic [SHIFT_W-1:0] shift = '0;
   logic busy, done, out_we, class_valid;
   logic [IN_AW-1:0] in_addr;
   logic [W_AW-1:0] w_addr;
   logic [OUT_AW-1:0] b_addr, out_addr, class_idx;
   logic signed [DATA_W-1:0] in_data = '0, w_data = '0, out_data;
   logic signed [ACC_W-1:0] b_data = '0;

   logic signed [DATA_W-1:0] in_mem [2**IN_AW];
   logic signed [DATA_W-1:0] w_mem  [2**W_AW];
   logic signed [ACC_W-1:0]  b_mem  [2**OUT_AW];

   int n_cmp = 0, n_bad = 0;
   int wr_addr_q[$], wr_data_q[$];
   bit prev_we = 1'b0;
   int consec = 0;

   always #5 clk = ~clk;

   fc_layer_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N_IN(N_IN), .N_OUT(N_OUT), .SHIFT_W(SHIFT_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_relu_en(relu_en), .i_shift(shift),
      .o_busy(busy), .o_done(done), .o_in_addr(in_addr), .i_in_data(in_data),
      .o_w_addr(w_addr), .i_w_data(w_data), .o_b_addr(b_addr), .i_b_data(b_data),
      .o_out_we(out_we), .o_out_addr(out_addr), .o_out_data(out_data),
      .o_class_idx(class_idx), .o_class_valid(class_valid));

   // Synchronous-read BRAMs, one cycle latency.
   always @(posedge clk) begin
      in_data <= in_mem[in_addr];
      w_data  <= w_mem[w_addr];
      b_data  <= b_mem[b_addr];
   end

   always @(negedge clk) begin
      if (out_we === 1'b1) begin
         wr_addr_q.push_back(int'(out_addr));
         wr_data_q.push_back(int'(out_data));
         if (prev_we) consec++;
      end
      prev_we = (out_we === 1'b1);
   end

   function automatic int ref_out(int o, bit relu, int sh);
      longint acc, r;
      acc = longint'(b_mem[o]);
      for (int i = 0; i < N_IN; i++) acc += longint'(in_mem[i]) * longint'(w_mem[o*N_IN+i]);
      acc = acc & 64'hFFFFFF;
      if (acc >= 64'h800000) acc -= 64'h1000000;
      r = acc + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : 64'sd0);
      r = r >>> sh;
      if (relu && r < 0) r = 0;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      return int'(r);
   endfunction

   function automatic int ref_argmax(bit relu, int sh);
      int best, idx;
      best = ref_out(0, relu, sh);
      idx = 0;
      for (int o = 1; o < N_OUT; o++)
         if (ref_out(o, relu, sh) > best) begin best = ref_out(o, relu, sh); idx = o; end
      return idx;
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 2**IN_AW; i++) in_mem[i] = '0;
      for (int i = 0; i < 2**W_AW; i++) w_mem[i] = '0;
      for (int i = 0; i < 2**OUT_AW; i++) b_mem[i] = '0;
   endtask

   task automatic load_random();
      for (int i = 0; i < N_IN; i++) in_mem[i] = DATA_W'($urandom);
      for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = DATA_W'($urandom);
      for (int o = 0; o < N_OUT; o++)
         b_mem[o] = ($urandom_range(0, 3) == 0) ? ACC_W'($urandom) : ACC_W'($urandom_range(0, 16383)) - 24'sd8192;
   endtask

   // One run with start pulsed for a single cycle; cycle 1 is the first cycle after the sampling edge.
   task automatic run_pass(input bit relu, input int sh, output int done_cyc, output int cidx, output int cvld);
      wr_addr_q.delete(); wr_data_q.delete(); consec = 0;
      @(negedge clk);
      relu_en = relu; shift = SHIFT_W'(sh); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      done_cyc = -1; cidx = -1; cvld = -1;
      for (int c = 1; c <= 200; c++) begin
         if (done === 1'b1) begin done_cyc = c; cidx = int'(class_idx); cvld = int'(class_valid); break; end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if ({busy, done, out_we, class_valid} !== 4'b0) begin n_bad++;
         $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, out_we, class_valid}); end
      n_cmp++; if ({in_addr, w_addr, b_addr, out_addr, class_idx} !== '0) begin n_bad++;
         $display("FAIL reset_addr: got %h expected 0", {in_addr, w_addr, b_addr, out_addr, class_idx}); end
      n_cmp++; if (out_data !== 8'sd0) begin n_bad++;
         $display("FAIL reset_out_data: got %0d expected 0", out_data); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int exp0 [N_OUT] = '{10, -10, 110, -90, 17};
      int exp1 [N_OUT] = '{10, 0, 110, 0, 17};
      int dc, ci, cv, got;
      clear_mem();
      for (int i = 0; i < N_IN; i++) in_mem[i] = DATA_W'(i + 1);
      for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = 8'sd1;
      b_mem[0] = 24'sd0; b_mem[1] = -24'sd20; b_mem[2] = 24'sd100; b_mem[3] = -24'sd100; b_mem[4] = 24'sd7;
      for (int r = 0; r < 2; r++) begin
         run_pass(r[0], 0, dc, ci, cv);
         n_cmp++; if (dc !== RUN_CYC) begin n_bad++;
            $display("FAIL basic_done_cycle relu=%0d: got %0d expected %0d", r, dc, RUN_CYC); end
         n_cmp++; if (wr_data_q.size() !== N_OUT || consec !== 0) begin n_bad++;
            $display("FAIL basic_writes relu=%0d: got %0d writes %0d consecutive expected %0d 0", r, wr_data_q.size(), consec, N_OUT); end
         for (int j = 0; j < N_OUT; j++) begin
            got = (j < wr_data_q.size()) ? wr_data_q[j] : -999;
            n_cmp++; if (got !== ((r == 0) ? exp0[j] : exp1[j]) || wr_addr_q[j] !== j) begin n_bad++;
               $display("FAIL basic_out relu=%0d n=%0d: got %0d expected %0d", r, j, got, (r == 0) ? exp0[j] : exp1[j]); end
         end
      end
   endtask

   task automatic test_requant();
      int shs [4] = '{3, 0, 1, 31};
      int exps [4][N_OUT] = '{'{125, 127, -128, 0, 0}, '{127, 127, -128, 3, -3},
                              '{127, 127, -128, 2, -1}, '{0, 0, 0, 0, 0}};
      int dc, ci, cv, got;
      clear_mem();
      for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = DATA_W'($urandom);
      b_mem[0] = 24'sd1000; b_mem[1] = 24'sd5000; b_mem[2] = -24'sd5000; b_mem[3] = 24'sd3; b_mem[4] = -24'sd3;
      for (int t = 0; t < 4; t++) begin
         run_pass(1'b0, shs[t], dc, ci, cv);
         for (int j = 0; j < N_OUT; j++) begin
            got = (j < wr_data_q.size()) ? wr_data_q[j] : -999;
            n_cmp++; if (got !== exps[t][j]) begin n_bad++;
               $display("FAIL requant sh=%0d n=%0d: got %0d expected %0d", shs[t], j, got, exps[t][j]); end
         end
      end
   endtask

   task automatic test_random();
      int dc, ci, cv, got, sh;
      bit relu;
      for (int t = 0; t < 8; t++) begin
         load_random();
         sh = $urandom_range(0, 12);
         relu = 1'($urandom);
         run_pass(relu, sh, dc, ci, cv);
         n_cmp++; if (dc !== RUN_CYC || wr_data_q.size() !== N_OUT || consec !== 0) begin n_bad++;
            $display("FAIL random_timing t=%0d: got done %0d writes %0d consec %0d", t, dc, wr_data_q.size(), consec); end
         for (int j = 0; j < N_OUT; j++) begin
            got = (j < wr_data_q.size()) ? wr_data_q[j] : -999;
            n_cmp++; if (got !== ref_out(j, relu, sh) || wr_addr_q[j] !== j) begin n_bad++;
               $display("FAIL random_out t=%0d n=%0d: got %0d expected %0d", t, j, got, ref_out(j, relu, sh)); end
         end
         n_cmp++; if (ci !== (ARGMAX ? ref_argmax(relu, sh) : 0) || cv !== int'(ARGMAX)) begin n_bad++;
            $display("FAIL random_class t=%0d: got idx %0d vld %0d expected %0d %0d", t, ci, cv, ARGMAX ? ref_argmax(relu, sh) : 0, ARGMAX); end
      end
   endtask

   task automatic test_argmax();
      int dc, ci, cv;
      clear_mem();
      b_mem[0] = 24'sd3; b_mem[1] = 24'sd9; b_mem[2] = -24'sd2; b_mem[3] = 24'sd9; b_mem[4] = 24'sd1;
      run_pass(1'b0, 0, dc, ci, cv);
      n_cmp++; if (ci !== (ARGMAX ? 1 : 0) || cv !== int'(ARGMAX)) begin n_bad++;
         $display("FAIL argmax_done: got idx %0d vld %0d expected %0d %0d", ci, cv, ARGMAX ? 1 : 0, ARGMAX); end
      n_cmp++; if (int'(class_idx) !== (ARGMAX ? 1 : 0) || class_valid !== ARGMAX) begin n_bad++;
         $display("FAIL argmax_hold: got idx %0d vld %0d expected %0d %0d", class_idx, class_valid, ARGMAX ? 1 : 0, ARGMAX); end
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n_cmp++; if (class_valid !== 1'b0 || busy !== 1'b1) begin n_bad++;
         $display("FAIL argmax_clear: got vld %0d busy %0d expected 0 1", class_valid, busy); end
      for (int c = 0; c < 60 && busy === 1'b1; c++) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int done_at[$];
      int got;
      load_random();
      wr_addr_q.delete(); wr_data_q.delete(); consec = 0;
      @(negedge clk); relu_en = 1'b0; shift = 5'd2; start = 1'b1;
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         if (done === 1'b1) done_at.push_back(c);
      end
      start = 1'b0;
      @(negedge clk);
      n_cmp++; if (done_at.size() !== 2 || done_at[0] !== RUN_CYC || done_at[1] !== 2*RUN_CYC+1) begin n_bad++;
         $display("FAIL b2b_done: got %0d pulses first %0d expected 2 at %0d and %0d", done_at.size(),
                  (done_at.size() > 0) ? done_at[0] : -1, RUN_CYC, 2*RUN_CYC+1); end
      n_cmp++; if (wr_data_q.size() !== 2*N_OUT || consec !== 0 || busy !== 1'b0) begin n_bad++;
         $display("FAIL b2b_writes: got %0d writes %0d consec busy %0d expected %0d 0 0", wr_data_q.size(), consec, busy, 2*N_OUT); end
      for (int j = 0; j < 2*N_OUT; j++) begin
         got = (j < wr_data_q.size()) ? wr_data_q[j] : -999;
         n_cmp++; if (got !== ref_out(j % N_OUT, 1'b0, 2)) begin n_bad++;
            $display("FAIL b2b_out w=%0d: got %0d expected %0d", j, got, ref_out(j % N_OUT, 1'b0, 2)); end
      end
   endtask

   task automatic test_reset_mid();
      int dc, ci, cv, got;
      load_random();
      wr_addr_q.delete(); wr_data_q.delete(); consec = 0;
      @(negedge clk); relu_en = 1'b1; shift = 5'd1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0 || out_we !== 1'b0 || done !== 1'b0 || class_valid !== 1'b0) begin n_bad++;
         $display("FAIL midreset_drop: got busy %0d we %0d done %0d vld %0d expected 0", busy, out_we, done, class_valid); end
      repeat (3) @(negedge clk);
      n_cmp++; if (wr_data_q.size() !== 1) begin n_bad++;
         $display("FAIL midreset_writes: got %0d expected 1", wr_data_q.size()); end
      rst_n = 1'b1;
      run_pass(1'b0, 4, dc, ci, cv);
      n_cmp++; if (dc !== RUN_CYC || wr_data_q.size() !== N_OUT) begin n_bad++;
         $display("FAIL midreset_rerun: got done %0d writes %0d expected %0d %0d", dc, wr_data_q.size(), RUN_CYC, N_OUT); end
      for (int j = 0; j < N_OUT; j++) begin
         got = (j < wr_data_q.size()) ? wr_data_q[j] : -999;
         n_cmp++; if (got !== ref_out(j, 1'b0, 4)) begin n_bad++;
            $display("FAIL midreset_out n=%0d: got %0d expected %0d", j, got, ref_out(j, 1'b0, 4)); end
      end
   endtask

   initial begin
      clear_mem();
      test_reset();
      test_basic();
      test_requant();
      test_random();
      test_argmax();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
